// File: rtl/playfield_lock_sequencer.sv
// Merges a landed tetromino into the row-organised field RAM, then removes full rows in one bottom-up pass.
// Optional score output enabled by defining PLS_SCORE_EN.
module playfield_lock_sequencer #(
  parameter int unsigned ROWS = 20,
  parameter int unsigned COLS = 10,
  parameter int unsigned RW   = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 lock_req,
  input  logic [3:0][RW-1:0]   blocks_xpos,
  input  logic [3:0][RW-1:0]   blocks_ypos,
  output logic [RW-1:0]        rd_addr,
  input  logic [COLS-1:0]      rd_data,
  output logic [RW-1:0]        wr_addr,
  output logic [COLS-1:0]      wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 lock_ack,
  output logic [2:0]           lines_cleared,
  output logic                 lock_err
`ifdef PLS_SCORE_EN
  ,
  output logic [19:0]          score
`endif
);

  localparam logic [RW-1:0] ROW_LIM  = RW'(ROWS);
  localparam logic [RW-1:0] COL_LIM  = RW'(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MERGE,
    S_SCAN,
    S_FILL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          fill_q, fill_d;
  logic                err_q, err_d;
  logic [3:0][RW-1:0]  xpos_q, xpos_d;
  logic [3:0][RW-1:0]  ypos_q, ypos_d;
  logic [RW-1:0]       rd_addr_d, wr_addr_d;
  logic                busy_d, ack_d, lock_err_d;
  logic [2:0]          lines_d;
  logic [2:0]          cnt_inc, cnt_fin;
  logic                blk_ok;

  // cnt saturates at 4: a tetromino can complete at most four rows
  assign cnt_inc = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
  assign blk_ok  = (ypos_q[k_q] < ROW_LIM) && (xpos_q[k_q] < COL_LIM);

  // next-state, next-register and write-port logic
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    err_d      = err_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    rd_addr_d  = rd_addr;
    wr_addr_d  = wr_addr;
    busy_d     = busy;
    lines_d    = lines_cleared;
    ack_d      = 1'b0;
    lock_err_d = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    cnt_fin    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (lock_req) begin
          xpos_d    = blocks_xpos;
          ypos_d    = blocks_ypos;
          err_d     = 1'b0;
          k_d       = 2'd0;
          rd_addr_d = blocks_ypos[0];
          wr_addr_d = blocks_ypos[0];
          busy_d    = 1'b1;
          state_d   = S_MERGE;
        end
      end

      S_MERGE: begin
        if (blk_ok) begin
          wr_en   = 1'b1;
          wr_data = rd_data | (COLS'(1) << xpos_q[k_q]);
        end else begin
          err_d = 1'b1;
        end
        if (k_q == 2'd3) begin
          rd_addr_d = ROW_LAST;
          wr_addr_d = ROW_LAST;
          cnt_d     = 3'd0;
          state_d   = S_SCAN;
        end else begin
          k_d       = k_q + 2'd1;
          rd_addr_d = ypos_q[k_q + 2'd1];
          wr_addr_d = ypos_q[k_q + 2'd1];
        end
      end

      // rd_addr is the source row, wr_addr the destination row
      S_SCAN: begin
        if (&rd_data) begin
          cnt_fin = cnt_inc;
        end else begin
          if (rd_addr != wr_addr) begin
            wr_en   = 1'b1;
            wr_data = rd_data;
          end
          wr_addr_d = wr_addr - RW'(1);
        end
        cnt_d = cnt_fin;
        if (rd_addr == '0) begin
          if (cnt_fin == 3'd0) begin
            lines_d    = cnt_fin;
            ack_d      = 1'b1;
            lock_err_d = err_q;
            state_d    = S_DONE;
          end else begin
            fill_d  = cnt_fin;
            state_d = S_FILL;
          end
        end else begin
          rd_addr_d = rd_addr - RW'(1);
        end
      end

      S_FILL: begin
        wr_en     = 1'b1;
        wr_data   = '0;
        wr_addr_d = wr_addr - RW'(1);
        fill_d    = fill_q - 3'd1;
        if (fill_q == 3'd1) begin
          lines_d    = cnt_q;
          ack_d      = 1'b1;
          lock_err_d = err_q;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_IDLE;
      k_q           <= 2'd0;
      cnt_q         <= 3'd0;
      fill_q        <= 3'd0;
      err_q         <= 1'b0;
      xpos_q        <= '0;
      ypos_q        <= '0;
      rd_addr       <= '0;
      wr_addr       <= '0;
      busy          <= 1'b0;
      lock_ack      <= 1'b0;
      lines_cleared <= 3'd0;
      lock_err      <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      err_q         <= err_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      rd_addr       <= rd_addr_d;
      wr_addr       <= wr_addr_d;
      busy          <= busy_d;
      lock_ack      <= ack_d;
      lines_cleared <= lines_d;
      lock_err      <= lock_err_d;
    end
  end

`ifdef PLS_SCORE_EN
  logic [10:0] pts;
  logic [20:0] score_sum;

  always_comb begin
    pts = 11'd0;
    case (lines_cleared)
      3'd1:    pts = 11'd40;
      3'd2:    pts = 11'd100;
      3'd3:    pts = 11'd300;
      3'd4:    pts = 11'd1200;
      default: pts = 11'd0;
    endcase
    score_sum = {1'b0, score} + 21'(pts);
  end

  // score is credited in the ack cycle and saturates at all ones
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score <= 20'd0;
    end else if (state_q == S_DONE) begin
      score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end
  end
`endif

endmodule
